flex_updown_counter: RTL and testbench
======================================

FLEX_UPDOWN_COUNTER -- requirements
Module: flex_updown_counter

Interface
REQ-001 Parameter NUM_CNT_BITS, default 4: counter, rollover and load width in bits; legal values are 2 to 32.
REQ-002 Port CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port n_rst  input  1  asynchronous, active-low reset.
REQ-004 Port clear  input  1  synchronous clear of the count.
REQ-005 Port count_enable  input  1  advances the count by one step per cycle.
REQ-006 Port count_dir  input  1  direction: 1 = up, 0 = down.
REQ-007 Port load  input  1  synchronous load of load_val.
REQ-008 Port load_val  input  NUM_CNT_BITS  load value.
REQ-009 Port rollover_val  input  NUM_CNT_BITS  terminal value of the count range 0..rollover_val.
REQ-010 Port count_out  output  NUM_CNT_BITS  registered count.
REQ-011 Port rollover_flag  output  1  registered; high exactly while count_out == rollover_val.
REQ-012 Port zero_flag  output  1  registered; high exactly while count_out == 0.
REQ-013 Port wrap_pulse  output  1  registered; high for one cycle when count_out has just taken a wrap value.

Function
REQ-014 Next-state priority SHALL be clear > load > count_enable > hold.
REQ-015 clear: next count_out = 0; wrap_pulse = 0.
REQ-016 load: next count_out = min(load_val, rollover_val); wrap_pulse = 0.
REQ-017 Up step: if count_out >= rollover_val, next = 1 and wrap_pulse = 1; otherwise next = count_out + 1.
REQ-018 Down step: if count_out <= 1 or count_out > rollover_val, next = rollover_val and wrap_pulse = 1; otherwise next = count_out - 1.
REQ-019 rollover_val == 0: enabled steps SHALL drive next = 0 with wrap_pulse = 0; clear and load behave normally.
REQ-020 rollover_val may change at any cycle; comparisons SHALL use the value sampled at the same clock edge.
REQ-021 rollover_flag and zero_flag SHALL be computed from the next count and the sampled rollover_val, so they align with count_out with no extra latency.
REQ-022 Arithmetic SHALL be unsigned NUM_CNT_BITS wide and SHALL never wrap through 2^NUM_CNT_BITS.
REQ-023 count_enable changes SHALL take effect at the next edge; latency from input to count_out is one cycle.

Reset
REQ-024 While n_rst = 0, all of the following SHALL hold immediately, independent of CLK:
- count_out = 0
- rollover_flag = 0
- zero_flag = 1
- wrap_pulse = 0
REQ-025 The first active edge after n_rst is released SHALL apply normal next-state rules.
REQ-026 Reset asserted mid-count SHALL discard the count; no partial step occurs.

Configuration
REQ-027 Macro FLEX_COUNTER_SAT_EN, when defined, SHALL add port sat_mode (input, 1 bit).
REQ-028 With sat_mode = 1:
- up steps hold at rollover_val
- down steps hold at 0
- wrap_pulse stays 0
- a down step from count_out > rollover_val loads rollover_val
REQ-029 Without FLEX_COUNTER_SAT_EN, the sat_mode port SHALL be absent and behaviour SHALL be wrap-only, as in REQ-017 and REQ-018.

Verification (NUM_CNT_BITS = 4)
REQ-030 Up wrap: rollover_val = 5, dir = 1, enable held for 7 cycles from reset -> count 1,2,3,4,5,1,2; rollover_flag high while count = 5; wrap_pulse high one cycle with count = 1.
REQ-031 Down wrap: load_val = 2, then down with rollover_val = 9 -> count 2,1,9,8; wrap_pulse with count = 9; zero_flag never high.
REQ-032 Priority: clear = load = enable = 1 with load_val = 7 -> count 0; then load = enable = 1 -> count 7; then load_val = 15 with rollover_val = 10 -> count 10.
REQ-033 Shrinking range: count = 8, rollover_val changed to 3, up step -> count 1 with wrap_pulse; down step from 8 -> count 3 with wrap_pulse.
REQ-034 Reset mid-count: count = 6, n_rst pulsed low between edges -> count_out = 0 and zero_flag = 1 before the next edge; counting resumes at 1.
REQ-035 FLEX_COUNTER_SAT_EN defined, sat_mode = 1, rollover_val = 3, up for 6 cycles -> count 1,2,3,3,3,3 with no wrap_pulse; down for 5 cycles -> 2,1,0,0,0.

Source files
------------

// File: rtl/flex_updown_counter.sv
// Up/down wrap counter with range 0..rollover_val, load/clear and registered flags.
// Optional saturating mode enabled by defining FLEX_COUNTER_SAT_EN (adds port sat_mode).
module flex_updown_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    CLK,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    count_dir,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
`ifdef FLEX_COUNTER_SAT_EN
  input  logic                    sat_mode,
`endif
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    zero_flag,
  output logic                    wrap_pulse
);

  localparam logic [NUM_CNT_BITS-1:0] CNT_ZERO = {NUM_CNT_BITS{1'b0}};
  localparam logic [NUM_CNT_BITS-1:0] CNT_ONE  = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};

  logic [NUM_CNT_BITS-1:0] count_r;
  logic                    rollover_r;
  logic                    zero_r;
  logic                    wrap_r;

  logic [NUM_CNT_BITS-1:0] next_cnt_s;
  logic                    next_wrap_s;
  logic                    next_roll_s;
  logic                    next_zero_s;
  logic                    sat_s;
  logic [NUM_CNT_BITS:0]   wrap_res_s;

  // Wrapping step, returns {wrap, next}; never passes through 2^NUM_CNT_BITS.
  function automatic logic [NUM_CNT_BITS:0] wrap_step(
    input logic [NUM_CNT_BITS-1:0] cnt,
    input logic [NUM_CNT_BITS-1:0] rv,
    input logic                    dir
  );
    logic [NUM_CNT_BITS:0] res;
    case (dir)
      1'b1: begin
        if (cnt >= rv) res = {1'b1, CNT_ONE};
        else           res = {1'b0, cnt + CNT_ONE};
      end
      1'b0: begin
        if ((cnt <= CNT_ONE) || (cnt > rv)) res = {1'b1, rv};
        else                                res = {1'b0, cnt - CNT_ONE};
      end
      default: res = {1'b0, cnt};
    endcase
    return res;
  endfunction

  // Saturating step: clamps at the range ends instead of wrapping.
  function automatic logic [NUM_CNT_BITS-1:0] sat_step(
    input logic [NUM_CNT_BITS-1:0] cnt,
    input logic [NUM_CNT_BITS-1:0] rv,
    input logic                    dir
  );
    logic [NUM_CNT_BITS-1:0] res;
    case (dir)
      1'b1: begin
        if (cnt >= rv) res = rv;
        else           res = cnt + CNT_ONE;
      end
      1'b0: begin
        if (cnt > rv)              res = rv;
        else if (cnt == CNT_ZERO)  res = CNT_ZERO;
        else                       res = cnt - CNT_ONE;
      end
      default: res = cnt;
    endcase
    return res;
  endfunction

`ifdef FLEX_COUNTER_SAT_EN
  assign sat_s = sat_mode;
`else
  assign sat_s = 1'b0;
`endif

  assign wrap_res_s = wrap_step(count_r, rollover_val, count_dir);

  // Next-state selection: clear > load > enabled step > hold.
  always_comb begin
    next_cnt_s  = count_r;
    next_wrap_s = 1'b0;
    if (clear) begin
      next_cnt_s = CNT_ZERO;
    end else if (load) begin
      next_cnt_s = (load_val > rollover_val) ? rollover_val : load_val;
    end else if (count_enable) begin
      if (rollover_val == CNT_ZERO) begin
        next_cnt_s = CNT_ZERO;
      end else if (sat_s) begin
        next_cnt_s = sat_step(count_r, rollover_val, count_dir);
      end else begin
        next_wrap_s = wrap_res_s[NUM_CNT_BITS];
        next_cnt_s  = wrap_res_s[NUM_CNT_BITS-1:0];
      end
    end else begin
      next_cnt_s = count_r;
    end
  end

  // Flags come from the next count so they line up with count_out.
  always_comb begin
    next_roll_s = (next_cnt_s == rollover_val);
    next_zero_s = (next_cnt_s == CNT_ZERO);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge n_rst) begin
    if (!n_rst) begin
      count_r    <= CNT_ZERO;
      rollover_r <= 1'b0;
      zero_r     <= 1'b1;
      wrap_r     <= 1'b0;
    end else begin
      count_r    <= next_cnt_s;
      rollover_r <= next_roll_s;
      zero_r     <= next_zero_s;
      wrap_r     <= next_wrap_s;
    end
  end

  assign count_out     = count_r;
  assign rollover_flag = rollover_r;
  assign zero_flag     = zero_r;
  assign wrap_pulse    = wrap_r;

endmodule

// File: tb/tb_flex_updown_counter.sv
// Directed bench for flex_updown_counter (NUM_CNT_BITS = 4); saturation test under FLEX_COUNTER_SAT_EN.
module tb_flex_updown_counter;

  logic       CLK;
  logic       n_rst;
  logic       clear;
  logic       count_enable;
  logic       count_dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag;
  logic       zero_flag;
  logic       wrap_pulse;
`ifdef FLEX_COUNTER_SAT_EN
  logic       sat_mode;
`endif

  int total_cnt;
  int bad_cnt;

  flex_updown_counter #(.NUM_CNT_BITS(4)) dut (
    .CLK(CLK),
    .n_rst(n_rst),
    .clear(clear),
    .count_enable(count_enable),
    .count_dir(count_dir),
    .load(load),
    .load_val(load_val),
    .rollover_val(rollover_val),
`ifdef FLEX_COUNTER_SAT_EN
    .sat_mode(sat_mode),
`endif
    .count_out(count_out),
    .rollover_flag(rollover_flag),
    .zero_flag(zero_flag),
    .wrap_pulse(wrap_pulse)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_val(input string tag, input int obs, input int exp_v);
    total_cnt = total_cnt + 1;
    if (obs !== exp_v) begin
      bad_cnt = bad_cnt + 1;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_all(input string tag, input int c, input int rf, input int zf, input int wp);
    check_val({tag, "_cnt"},  int'(count_out), c);
    check_val({tag, "_roll"}, int'(rollover_flag), rf);
    check_val({tag, "_zero"}, int'(zero_flag), zf);
    check_val({tag, "_wrap"}, int'(wrap_pulse), wp);
  endtask

  int exp_up[7]   = '{1, 2, 3, 4, 5, 1, 2};
  int exp_dn[3]   = '{1, 9, 8};
  int exp_sup[6]  = '{1, 2, 3, 3, 3, 3};
  int exp_sdn[5]  = '{2, 1, 0, 0, 0};

  initial begin
    total_cnt    = 0;
    bad_cnt      = 0;
    n_rst        = 1'b0;
    clear        = 1'b0;
    count_enable = 1'b0;
    count_dir    = 1'b1;
    load         = 1'b0;
    load_val     = 4'd0;
    rollover_val = 4'd5;
`ifdef FLEX_COUNTER_SAT_EN
    sat_mode     = 1'b0;
`endif

    // reset state, held across an edge
    #12;
    check_all("reset", 0, 0, 1, 0);
    n_rst = 1'b1;

    // up wrap with rollover_val = 5
    count_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check_all("upwrap", exp_up[i], (exp_up[i] == 5) ? 1 : 0, 0, (i == 5) ? 1 : 0);
    end

    // down wrap: load 2, then down with rollover_val = 9
    count_enable = 1'b0;
    load         = 1'b1;
    load_val     = 4'd2;
    rollover_val = 4'd9;
    step();
    check_all("dnload", 2, 0, 0, 0);
    load         = 1'b0;
    count_enable = 1'b1;
    count_dir    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("dnwrap", exp_dn[i], (exp_dn[i] == 9) ? 1 : 0, 0, (i == 1) ? 1 : 0);
    end

    // priority clear > load > enable, then load clamp
    clear        = 1'b1;
    load         = 1'b1;
    count_enable = 1'b1;
    load_val     = 4'd7;
    rollover_val = 4'd10;
    step();
    check_all("prio_clr", 0, 0, 1, 0);
    clear = 1'b0;
    step();
    check_all("prio_load", 7, 0, 0, 0);
    load_val = 4'd15;
    step();
    check_all("load_clamp", 10, 1, 0, 0);

    // shrinking range, up step from 8 with rollover_val 3
    load_val = 4'd8;
    step();
    check_all("shr_load", 8, 0, 0, 0);
    load         = 1'b0;
    count_dir    = 1'b1;
    rollover_val = 4'd3;
    step();
    check_all("shr_up", 1, 0, 0, 1);

    // shrinking range, down step from 8
    load         = 1'b1;
    rollover_val = 4'd10;
    step();
    check_all("shr_load2", 8, 0, 0, 0);
    load         = 1'b0;
    count_dir    = 1'b0;
    rollover_val = 4'd3;
    step();
    check_all("shr_dn", 3, 1, 0, 1);

    // rollover_val = 0: enabled steps go to 0 without wrap
    rollover_val = 4'd0;
    step();
    check_all("rv0_dn", 0, 1, 1, 0);
    count_dir = 1'b1;
    step();
    check_all("rv0_up", 0, 1, 1, 0);

    // reset mid-count
    count_enable = 1'b0;
    load         = 1'b1;
    load_val     = 4'd6;
    rollover_val = 4'd9;
    step();
    check_all("mid_load", 6, 0, 0, 0);
    load = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check_all("mid_rst", 0, 0, 1, 0);
    n_rst        = 1'b1;
    count_enable = 1'b1;
    count_dir    = 1'b1;
    step();
    check_all("resume", 1, 0, 0, 0);

    // hold when disabled
    count_enable = 1'b0;
    step();
    check_all("hold", 1, 0, 0, 0);

`ifdef FLEX_COUNTER_SAT_EN
    // saturating mode, rollover_val = 3
    clear = 1'b1;
    step();
    clear        = 1'b0;
    sat_mode     = 1'b1;
    rollover_val = 4'd3;
    count_enable = 1'b1;
    count_dir    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check_all("sat_up", exp_sup[i], (exp_sup[i] == 3) ? 1 : 0, 0, 0);
    end
    count_dir = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_all("sat_dn", exp_sdn[i], 0, (exp_sdn[i] == 0) ? 1 : 0, 0);
    end
    sat_mode = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
